in_port_unit: RTL and testbench
===============================

# in_port_unit

Buffered input-port peripheral for the RISC CPU datapath: the source side of the `IN` instruction, and the counterpart of the output port driven by `OutPort_In`. An external device pushes 32-bit words over a valid/ready handshake into a small FIFO. The CPU reads one word per `InPort_Out` assertion, and the word is driven onto the datapath bus. Each read consumes exactly one entry, however many cycles `InPort_Out` is held.

## Interface
Parameters:
- `WIDTH`, 32, data word width
- `DEPTH`, 4, FIFO entries (power of two, ≥2)

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge
- `clear`  in  1  synchronous, active-high reset
- `dev_data`  in  WIDTH  word offered by the external device
- `dev_valid`  in  1  device has a word on `dev_data`
- `dev_ready`  out  1  FIFO can accept a word this cycle
- `InPort_Out`  in  1  CPU read strobe (control-unit T-state signal)
- `bus_out`  out  WIDTH  value driven toward the bus mux; zero when not reading
- `data_avail`  out  1  FIFO non-empty
- `count`  out  log2(DEPTH)+1  number of valid entries
- `underflow`  out  1  sticky: a read started while the FIFO was empty

## Operation
- Storage: `DEPTH` x `WIDTH` array, with `wr_ptr`/`rd_ptr` of log2(DEPTH) bits that wrap modulo `DEPTH`, plus a `count` register.
- Push: occurs when `dev_valid && dev_ready`. It writes `dev_data` at `wr_ptr`, increments `wr_ptr`, and increments `count`.
- `dev_ready = (count != DEPTH)`. This is combinational from `count` only, with no dependence on `dev_valid`.
- Read FSM states:
  - IDLE to HOLD on `InPort_Out`, independent of empty.
  - HOLD to HOLD while `InPort_Out` stays high.
  - HOLD to IDLE when `InPort_Out` is low.
- Read start is the first cycle of `InPort_Out` seen in IDLE.
  - Non-empty: `bus_out` = mem[`rd_ptr`] combinationally. At the clock edge, that value is latched into `rd_hold`, `rd_ptr` increments, and `count` decrements (a pop).
  - Empty: `bus_out` = 0. At the edge, `rd_hold` gets 0, there is no pop, and `underflow` is set.
- HOLD with `InPort_Out` high: `bus_out` = `rd_hold`, with no further pops.
- `InPort_Out` low: `bus_out` = 0 in all states.
- A push and a pop in the same edge leave `count` unchanged, and both pointers advance.
- When full, `dev_ready` = 0. A pop on that edge does not enable a same-cycle push; `dev_ready` rises the next cycle.
- When empty, a push and a read start on the same edge return 0 and flag `underflow`; there is no bypass. The pushed word is retained.
- `data_avail = (count != 0)`.
- `underflow` is cleared only by `clear`.

## Timing
- `clear` sampled high at an edge: pointers, `count`, `rd_hold`, and `underflow` go to 0, and the FSM goes to IDLE. This takes priority over a simultaneous push or pop, which are discarded.
- Output values while in reset and immediately after:
  - `dev_ready` = 1
  - `data_avail` = 0
  - `count` = 0
  - `bus_out` = 0 (unless `InPort_Out` is high)
  - `underflow` = 0
- Push-to-available latency: a word accepted at edge N is readable (`data_avail` = 1) after edge N.
- Read latency: 0 cycles. `bus_out` is valid in the same cycle `InPort_Out` rises, so Yin/Rin can capture it at the next edge.
- Back-to-back reads require `InPort_Out` to be low for at least one cycle between them.
- Throughput: one push per cycle sustained while not full.
- `clear` asserted during HOLD: the FSM returns to IDLE. If `InPort_Out` is still high on the cycle after `clear`, that cycle counts as a new read start.

## Structure
- Shared package `io_port_pkg`:
  - read-FSM state enum (IDLE, HOLD)
  - `IO_WIDTH` = 32
  - default `IO_DEPTH` = 4
- One sub-module, `io_fifo` (array, pointers, count, full/empty). The read FSM, `rd_hold`, and `underflow` live in `in_port_unit`.
- The top-level CPU instantiates this in place of the raw `InPortData` register, with `bus_out` feeding the InPort bus-mux input.

## Test plan
- Reset then push A=32'h56781234: `count`=1, `data_avail`=1. Pulse `InPort_Out` for one cycle: `bus_out`=32'h56781234 that cycle, then `count`=0 and `bus_out`=0 after.
- Push 4 words 32'h11, 22, 33, 44 with `dev_valid` held high, then offer 32'h55: `dev_ready`=0 after the 4th push and 32'h55 is not accepted. Read four times: 11, 22, 33, 44 in order.
- Hold `InPort_Out` for 3 cycles with FIFO holding 32'hAA, BB: `bus_out`=AA on all 3 cycles and `count` goes 2 to 1 only. The next pulse returns BB.
- Read while empty: `bus_out`=0, `underflow`=1 and stays set through later normal reads until `clear`.
- Full FIFO, read start with `dev_valid` high: no push on that edge, `dev_ready`=1 the next cycle, push then accepted, `count` back to 4. After the final wrap, pointers read back in FIFO order (≥2·DEPTH words total).
- `clear` asserted mid-HOLD with `count`=3: next cycle `count`=0, `dev_ready`=1, `bus_out`=0 once `InPort_Out` drops.

Source files
------------

// File: rtl/io_port_pkg.sv
// Shared definitions for the CPU I/O port peripherals.
// Holds the read-FSM state type and the default port width and depth.
package io_port_pkg;

  localparam int unsigned IO_WIDTH = 32;
  localparam int unsigned IO_DEPTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rd_state_e;

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO with wrapping pointers and an occupancy counter.
// The caller must not push when full or pop when empty.
module io_fifo
  import io_port_pkg::*;
#(
  parameter int unsigned WIDTH = IO_WIDTH,
  parameter int unsigned DEPTH = IO_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    // Simultaneous push and pop leave the occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only valid entries are ever read out.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == CNT_W'(0));

endmodule

// File: rtl/in_port_unit.sv
// Buffered input port: the device pushes words into a FIFO, and each CPU
// read strobe pops exactly one word onto the bus, however long it is held.
module in_port_unit
  import io_port_pkg::*;
#(
  parameter int unsigned WIDTH = IO_WIDTH,
  parameter int unsigned DEPTH = IO_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [WIDTH-1:0] dev_data,
  input  logic             dev_valid,
  output logic             dev_ready,
  input  logic             InPort_Out,
  output logic [WIDTH-1:0] bus_out,
  output logic             data_avail,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  rd_state_e        state_q, state_d;
  logic [WIDTH-1:0] rd_hold_q, rd_hold_d;
  logic             underflow_q, underflow_d;

  logic             push_c;
  logic             pop_c;
  logic             rd_start_c;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_full;
  logic             fifo_empty;

  io_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .clear   (clear),
    .push    (push_c),
    .pop     (pop_c),
    .wr_data (dev_data),
    .rd_data (fifo_rd_data),
    .count   (count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign dev_ready  = !fifo_full;
  assign data_avail = !fifo_empty;
  assign underflow  = underflow_q;
  assign push_c     = dev_valid && dev_ready;
  assign rd_start_c = (state_q == IDLE) && InPort_Out;
  assign pop_c      = rd_start_c && !fifo_empty;

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= IDLE;
      rd_hold_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_hold_q   <= rd_hold_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (InPort_Out) state_d = HOLD;
      HOLD:    if (!InPort_Out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read start latches the popped word (or zero on underflow) for the hold phase.
  always_comb begin
    rd_hold_d   = rd_hold_q;
    underflow_d = underflow_q;
    bus_out     = '0;
    if (rd_start_c) begin
      rd_hold_d   = fifo_empty ? '0 : fifo_rd_data;
      underflow_d = underflow_q || fifo_empty;
    end
    if (InPort_Out) begin
      if (state_q == IDLE) begin
        bus_out = fifo_empty ? '0 : fifo_rd_data;
      end else begin
        bus_out = rd_hold_q;
      end
    end
  end

endmodule

// File: tb/tb_in_port_unit.sv
// Bench for in_port_unit: directed scenarios with literal checks, then random
// traffic, all compared every cycle against a queue-based model.
module tb_in_port_unit;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = 3;

  logic          clock = 1'b0;
  logic          clear = 1'b1;
  logic [W-1:0]  dev_data = '0;
  logic          dev_valid = 1'b0;
  logic          dev_ready;
  logic          InPort_Out = 1'b0;
  logic [W-1:0]  bus_out;
  logic          data_avail;
  logic [CW-1:0] count;
  logic          underflow;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  in_port_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clock      (clock),
    .clear      (clear),
    .dev_data   (dev_data),
    .dev_valid  (dev_valid),
    .dev_ready  (dev_ready),
    .InPort_Out (InPort_Out),
    .bus_out    (bus_out),
    .data_avail (data_avail),
    .count      (count),
    .underflow  (underflow)
  );

  always #5 clock = ~clock;

  // Reference: a queue of words, the word captured by the current read, and
  // whether the strobe was already high at the previous edge.
  logic [W-1:0] q[$];
  logic [W-1:0] m_held = '0;
  bit           m_prev = 1'b0;
  bit           m_uf   = 1'b0;

  always @(posedge clock) begin
    int sz;
    sz = q.size();
    if (clear) begin
      q.delete();
      m_held = '0;
      m_prev = 1'b0;
      m_uf   = 1'b0;
    end else begin
      if (InPort_Out && !m_prev) begin
        if (sz > 0) m_held = q.pop_front();
        else begin
          m_held = '0;
          m_uf   = 1'b1;
        end
      end
      if (dev_valid && sz < int'(D)) q.push_back(dev_data);
      m_prev = InPort_Out;
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle comparison, sampled mid-low-phase after inputs have settled.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (chk_en) begin
        logic [W-1:0] e_bus;
        if (!InPort_Out) e_bus = '0;
        else if (m_prev) e_bus = m_held;
        else e_bus = (q.size() > 0) ? q[0] : '0;
        chk("bus_out", bus_out, e_bus);
        chk("dev_ready", W'(dev_ready), W'(q.size() != int'(D)));
        chk("data_avail", W'(data_avail), W'(q.size() != 0));
        chk("count", W'(count), W'(q.size()));
        chk("underflow", W'(underflow), W'(m_uf));
      end
    end
  end

  task automatic step(input bit v, input logic [W-1:0] d, input bit rd, input bit clr);
    @(negedge clock);
    dev_valid  = v;
    dev_data   = d;
    InPort_Out = rd;
    clear      = clr;
    #2;
  endtask

  initial begin
    logic [W-1:0] words [4];
    step(0, '0, 0, 1);
    step(0, '0, 0, 1);
    step(0, '0, 0, 0);
    chk_en = 1'b1;
    chk("rst_count", W'(count), 0);
    chk("rst_ready", W'(dev_ready), 1);
    chk("rst_avail", W'(data_avail), 0);
    chk("rst_uf", W'(underflow), 0);
    chk("rst_bus", bus_out, 0);

    // Single push then a one-cycle read.
    step(1, 32'h5678_1234, 0, 0);
    step(0, '0, 1, 0);
    chk("a_bus", bus_out, 32'h5678_1234);
    chk("a_count", W'(count), 1);
    chk("a_avail", W'(data_avail), 1);
    step(0, '0, 0, 0);
    chk("a_count_after", W'(count), 0);
    chk("a_bus_after", bus_out, 0);

    // Fill, refuse a fifth word, drain in order.
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    for (int i = 0; i < 4; i++) step(1, words[i], 0, 0);
    step(1, 32'h55, 0, 0);
    chk("full_ready", W'(dev_ready), 0);
    chk("full_count", W'(count), 4);
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 1, 0);
      chk("drain_bus", bus_out, words[i]);
      step(0, '0, 0, 0);
    end
    chk("drain_empty", W'(data_avail), 0);

    // Held strobe pops once.
    step(1, 32'hAA, 0, 0);
    step(1, 32'hBB, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 1, 0);
      chk("hold_bus", bus_out, 32'hAA);
    end
    step(0, '0, 0, 0);
    chk("hold_count", W'(count), 1);
    step(0, '0, 1, 0);
    chk("hold_next", bus_out, 32'hBB);
    step(0, '0, 0, 0);

    // Underflow is sticky across later good reads.
    step(0, '0, 1, 0);
    chk("uf_bus", bus_out, 0);
    step(0, '0, 0, 0);
    chk("uf_set", W'(underflow), 1);
    step(1, 32'h77, 0, 0);
    step(0, '0, 1, 0);
    chk("uf_read", bus_out, 32'h77);
    step(0, '0, 0, 0);
    chk("uf_sticky", W'(underflow), 1);

    // Pop from full does not admit a same-edge push.
    for (int i = 0; i < 4; i++) step(1, 32'hA1 + W'(i), 0, 0);
    step(1, 32'hA5, 1, 0);
    chk("fullpop_bus", bus_out, 32'hA1);
    chk("fullpop_ready", W'(dev_ready), 0);
    step(1, 32'hA5, 0, 0);
    chk("fullpop_ready2", W'(dev_ready), 1);
    chk("fullpop_count", W'(count), 3);
    step(0, '0, 0, 0);
    chk("refill_count", W'(count), 4);
    for (int i = 0; i < 4; i++) begin
      step(0, '0, 1, 0);
      chk("wrap_bus", bus_out, 32'hA2 + W'(i));
      step(0, '0, 0, 0);
    end

    // Clear in the middle of a hold.
    for (int i = 0; i < 3; i++) step(1, 32'hC0 + W'(i), 0, 0);
    step(0, '0, 1, 0);
    chk("clr_bus", bus_out, 32'hC0);
    step(0, '0, 1, 1);
    chk("clr_count_pre", W'(count), 2);
    step(0, '0, 0, 0);
    chk("clr_count", W'(count), 0);
    chk("clr_ready", W'(dev_ready), 1);
    chk("clr_bus0", bus_out, 0);
    chk("clr_uf", W'(underflow), 0);
    // Strobe still high after clear starts a fresh read.
    step(0, '0, 1, 1);
    step(0, '0, 1, 0);
    chk("clr_restart_bus", bus_out, 0);
    step(0, '0, 0, 0);
    chk("clr_restart_uf", W'(underflow), 1);
    step(0, '0, 0, 1);

    // Random traffic checked only by the per-cycle model comparison.
    for (int n = 0; n < 3000; n++) begin
      step(bit'($urandom_range(0, 1)), W'($urandom),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 79) == 0));
    end
    step(0, '0, 0, 0);
    @(negedge clock);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
